data_axi_bridge: RTL and testbench
==================================

DATA_AXI_BRIDGE -- requirements
Module: data_axi_bridge

Interface
REQ-001 Ports SHALL be as listed in REQ-002..REQ-014; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 data_req, data_wr  in  1 each  upstream request valid / write(1) or read(0).
REQ-005 data_size  in  2  00 byte, 01 half, 10 word; 11 SHALL be treated as 10.
REQ-006 data_addr, data_wdata  in  32 each  byte address (upper bits pre-masked upstream) / store data, already lane-positioned.
REQ-007 data_addr_ok  out  1  request accepted this cycle.
REQ-008 data_data_ok  out  1  one-cycle pulse: read data valid or write response received.
REQ-009 data_rdata  out  32  read data, valid only while data_data_ok=1.
REQ-010 arvalid, araddr[31:0], arsize[2:0], arready(in)  AXI read-address channel.
REQ-011 rvalid(in), rdata[31:0](in), rlast(in), rready  AXI read-data channel.
REQ-012 awvalid, awaddr[31:0], awsize[2:0], awready(in); wvalid, wdata[31:0], wstrb[3:0], wlast, wready(in)  AXI write channels.
REQ-013 bvalid(in), bready  AXI write-response channel.
REQ-014 Constant outputs: arid=awid=wid=4'd1, arlen=awlen=4'd0, arburst=awburst=2'b01, arlock=awlock=0, arcache=awcache=0, arprot=awprot=0.

Function
REQ-015 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP; exactly one transaction outstanding.
REQ-016 data_addr_ok SHALL equal 1 only in IDLE (combinational); a request is accepted on data_req&data_addr_ok.
REQ-017 On acceptance, addr, size, wr, wdata and derived wstrb SHALL be latched; IDLE->RD_ADDR if read, IDLE->WR_REQ if write.
REQ-018 RD_ADDR: arvalid=1, araddr/arsize from latched values (arsize={1'b0,size}); on arready -> RD_DATA.
REQ-019 RD_DATA: rready=1; on rvalid: data_data_ok=1, data_rdata=rdata same cycle, -> IDLE; rresp ignored.
REQ-020 WR_REQ: awvalid and wvalid SHALL assert together in first cycle; each deasserts independently after its own handshake (aw_done/w_done flags); wlast=1.
REQ-021 WR_REQ -> WR_RESP when both handshakes complete, including both in the same cycle or in different cycles, order irrelevant.
REQ-022 WR_RESP: bready=1; on bvalid: data_data_ok=1 one cycle, -> IDLE; bresp ignored.
REQ-023 wstrb: size 00 -> 4'b0001<<addr[1:0]; size 01 -> 4'b0011<<{addr[1],1'b0}; size 10/11 -> 4'b1111.
REQ-024 Minimum read latency: accept (cycle 0), arready cycle 1, rvalid cycle 2 -> data_data_ok cycle 2; IDLE again cycle 3.
REQ-025 data_data_ok SHALL never assert outside RD_DATA/WR_RESP; at most one pulse per accepted request.
REQ-026 data_req while not IDLE SHALL be ignored (addr_ok=0); request is not lost, upstream holds it.
REQ-027 All AXI valid outputs SHALL stay asserted, with stable payload, until handshaken.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, clear aw_done/w_done, drive arvalid=awvalid=wvalid=rready=bready=data_data_ok=0, latched registers 0.
REQ-029 Reset mid-transaction SHALL abandon it; no data_data_ok SHALL follow for it after release.
REQ-030 First acceptance possible in first cycle after rst deasserts.

Structure
REQ-031 Shared package SHALL hold the state encoding, AXI constants (ID=1, BURST_INCR=2'b01, LEN0) and size codes.
REQ-032 One sub-module SHALL be natural: data_axi_wstrb (combinational size/addr -> wstrb); all else in one module.

Verification
REQ-033 Read word addr 0x0000_1004, arready immediate, rvalid 1 cycle later rdata 0xDEADBEEF -> araddr 0x1004, arsize 2, data_data_ok pulse with data_rdata 0xDEADBEEF, cycle 2.
REQ-034 Byte write addr 0x...0003 wdata 0xAB000000 -> wstrb 4'b1000, awsize 0, single data_data_ok after bvalid.
REQ-035 Write with wready 2 cycles before awready -> wvalid drops after W handshake, awvalid held; WR_RESP entered only after awready.
REQ-036 Half write addr 0x...0002, aw and w handshakes same cycle -> wstrb 4'b1100, next state WR_RESP, bready=1.
REQ-037 data_req held high during RD_DATA -> data_addr_ok=0 until IDLE, second request accepted exactly once.
REQ-038 rst asserted while in RD_DATA -> arvalid/rready 0 immediately; no data_data_ok after release for old request.

Source files
------------

// File: rtl/data_axi_bridge_pkg.sv
// Shared definitions for the data-bus to AXI bridge: FSM state encoding,
// fixed AXI attribute values and the upstream size codes.
package data_axi_bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_ADDR = 3'd1,
      ST_RD_DATA = 3'd2,
      ST_WR_REQ  = 3'd3,
      ST_WR_RESP = 3'd4
   } state_t;

   localparam logic [3:0] AXI_ID     = 4'd1;
   localparam logic [3:0] AXI_LEN0   = 4'd0;
   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_LOCK0  = 2'b00;
   localparam logic [3:0] AXI_CACHE0 = 4'b0000;
   localparam logic [2:0] AXI_PROT0  = 3'b000;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   // The reserved size code behaves as a full word.
   function automatic logic [1:0] norm_size(input logic [1:0] size);
      return (size == SIZE_RSVD) ? SIZE_WORD : size;
   endfunction

endpackage

// File: rtl/data_axi_bridge_wstrb.sv
// Byte-lane strobe generator: maps access size and low address bits onto
// the four write strobes of a 32-bit data bus.
module data_axi_bridge_wstrb
   import data_axi_bridge_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   // Select the lanes covered by the access, aligned to its natural size.
   always_comb begin
      wstrb = 4'b1111;
      case (size)
         SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
         default:   wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/data_axi_bridge.sv
// Single-outstanding bridge from a simple request/ok data bus to AXI.
// Reads go through AR then R; writes issue AW and W together, then wait on B.
module data_axi_bridge
   import data_axi_bridge_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   // upstream data bus
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   // AXI read address
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [3:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   output logic        rready,
   // AXI write address
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [3:0]  awlen,
   output logic [2:0]  awsize,
   output logic [1:0]  awburst,
   output logic [1:0]  awlock,
   output logic [3:0]  awcache,
   output logic [2:0]  awprot,
   output logic        awvalid,
   input  logic        awready,
   // AXI write data
   output logic [3:0]  wid,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wlast,
   output logic        wvalid,
   input  logic        wready,
   // AXI write response
   input  logic        bvalid,
   output logic        bready
);

   state_t      state;
   logic        aw_done;
   logic        w_done;
   logic        wr_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic [3:0]  wstrb_new;
   logic        aw_fire;
   logic        w_fire;
   logic        aw_all;
   logic        w_all;
   logic        unused_rlast;

   // Single beat only, so the last flag carries no information.
   assign unused_rlast = rlast;

   data_axi_bridge_wstrb u_wstrb (
      .size    (data_size),
      .addr_lo (data_addr[1:0]),
      .wstrb   (wstrb_new)
   );

   assign aw_fire = awvalid & awready;
   assign w_fire  = wvalid & wready;
   assign aw_all  = aw_done | aw_fire;
   assign w_all   = w_done | w_fire;

   assign data_addr_ok = (state == ST_IDLE);
   assign data_data_ok = ((state == ST_RD_DATA) & rvalid) |
                         ((state == ST_WR_RESP) & bvalid);
   assign data_rdata   = ((state == ST_RD_DATA) & ~wr_q) ? rdata : 32'h0;

   assign arid    = AXI_ID;
   assign arlen   = AXI_LEN0;
   assign arburst = BURST_INCR;
   assign arlock  = AXI_LOCK0;
   assign arcache = AXI_CACHE0;
   assign arprot  = AXI_PROT0;
   assign araddr  = addr_q;
   assign arsize  = {1'b0, size_q};

   assign awid    = AXI_ID;
   assign awlen   = AXI_LEN0;
   assign awburst = BURST_INCR;
   assign awlock  = AXI_LOCK0;
   assign awcache = AXI_CACHE0;
   assign awprot  = AXI_PROT0;
   assign awaddr  = addr_q;
   assign awsize  = {1'b0, size_q};

   assign wid     = AXI_ID;
   assign wdata   = wdata_q;
   assign wstrb   = wstrb_q;
   assign wlast   = 1'b1;

   // Transaction FSM with registered AXI handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         arvalid <= 1'b0;
         rready  <= 1'b0;
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         wr_q    <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         wstrb_q <= 4'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (data_req) begin
                  wr_q    <= data_wr;
                  size_q  <= norm_size(data_size);
                  addr_q  <= data_addr;
                  wdata_q <= data_wdata;
                  wstrb_q <= wstrb_new;
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  if (data_wr) begin
                     state   <= ST_WR_REQ;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                  end else begin
                     state   <= ST_RD_ADDR;
                     arvalid <= 1'b1;
                  end
               end
            end
            ST_RD_ADDR: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (rvalid) begin
                  rready <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            ST_WR_REQ: begin
               if (aw_fire) begin
                  awvalid <= 1'b0;
                  aw_done <= 1'b1;
               end
               if (w_fire) begin
                  wvalid <= 1'b0;
                  w_done <= 1'b1;
               end
               // Both channels done (together or at different times).
               if (aw_all & w_all) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  bready  <= 1'b1;
                  state   <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (bvalid) begin
                  bready <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_axi_bridge.sv
// Bench for data_axi_bridge: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the bridge.
module tb_data_axi_bridge;

   logic        clk;
   logic        rst;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [2:0]  arsize, arprot, awsize, awprot;
   logic [1:0]  arburst, arlock, awburst, awlock;
   logic        arvalid, arready, rvalid, rlast, rready;
   logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int total = 0;
   int bad = 0;
   int accepts = 0;

   // transaction-level model state
   bit          busy, m_wr, ar_done, aw_done_m, w_done_m;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;

   data_axi_bridge dut (
      .clk(clk), .rst(rst),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Lanes touched by an aligned access of 1, 2 or 4 bytes.
   function automatic logic [3:0] model_strb(input logic [1:0] sz, input logic [31:0] a);
      int n, nbytes, off, mask;
      n      = (sz == 2'd3) ? 2 : int'(sz);
      nbytes = 1 << n;
      off    = int'(a[1:0]) & ~(nbytes - 1);
      mask   = ((1 << nbytes) - 1) << off;
      return mask[3:0];
   endfunction

   function automatic logic [2:0] model_axsize(input logic [1:0] sz);
      return (sz == 2'd3) ? 3'd2 : {1'b0, sz};
   endfunction

   task automatic model_reset();
      busy = 0; m_wr = 0; ar_done = 0; aw_done_m = 0; w_done_m = 0;
   endtask

   task automatic slave_idle();
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
   endtask

   // Compare all outputs with the model, then advance the model across the
   // coming rising edge. Called just after a falling edge with inputs set.
   task automatic tick(output bit acc);
      bit e_ar, e_r, e_aw, e_w, e_b, e_ok;
      #1;
      e_ar = busy & !m_wr & !ar_done;
      e_r  = busy & !m_wr & ar_done;
      e_aw = busy & m_wr & !aw_done_m;
      e_w  = busy & m_wr & !w_done_m;
      e_b  = busy & m_wr & aw_done_m & w_done_m;
      e_ok = (e_r & rvalid) | (e_b & bvalid);
      chk("addr_ok", {31'b0, data_addr_ok}, {31'b0, !busy});
      chk("arvalid", {31'b0, arvalid}, {31'b0, e_ar});
      chk("rready",  {31'b0, rready},  {31'b0, e_r});
      chk("awvalid", {31'b0, awvalid}, {31'b0, e_aw});
      chk("wvalid",  {31'b0, wvalid},  {31'b0, e_w});
      chk("bready",  {31'b0, bready},  {31'b0, e_b});
      chk("data_ok", {31'b0, data_data_ok}, {31'b0, e_ok});
      if (e_ar) begin
         chk("araddr", araddr, m_addr);
         chk("arsize", {29'b0, arsize}, {29'b0, model_axsize(m_size)});
      end
      if (e_aw) begin
         chk("awaddr", awaddr, m_addr);
         chk("awsize", {29'b0, awsize}, {29'b0, model_axsize(m_size)});
      end
      if (e_w) begin
         chk("wdata", wdata, m_wdata);
         chk("wstrb", {28'b0, wstrb}, {28'b0, model_strb(m_size, m_addr)});
         chk("wlast", {31'b0, wlast}, 32'd1);
      end
      if (e_ok && !m_wr) chk("rdata", data_rdata, rdata);
      acc = 0;
      if (rst) begin
         if (!busy) begin
            if (data_req) begin
               busy = 1; m_wr = data_wr; m_size = data_size; m_addr = data_addr;
               m_wdata = data_wdata; ar_done = 0; aw_done_m = 0; w_done_m = 0;
               acc = 1; accepts++;
            end
         end else if (!m_wr) begin
            if (!ar_done) begin
               if (arready) ar_done = 1;
            end else if (rvalid) busy = 0;
         end else if (aw_done_m && w_done_m) begin
            if (bvalid) busy = 0;
         end else begin
            if (!aw_done_m && awready) aw_done_m = 1;
            if (!w_done_m && wready) w_done_m = 1;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Randomized AXI slave; R and B only offered when legal.
   task automatic slave_rand();
      arready = 1'($urandom_range(0, 1));
      awready = 1'($urandom_range(0, 1));
      wready  = 1'($urandom_range(0, 1));
      if (busy && !m_wr && ar_done) begin
         if (!rvalid && $urandom_range(0, 1) == 1) begin
            rvalid = 1; rdata = $urandom;
         end
      end else rvalid = 0;
      if (busy && m_wr && aw_done_m && w_done_m) begin
         if (!bvalid && $urandom_range(0, 1) == 1) bvalid = 1;
      end else bvalid = 0;
   endtask

   task automatic up_rand();
      if (!data_req && $urandom_range(0, 2) == 0) begin
         data_req   = 1;
         data_wr    = 1'($urandom_range(0, 1));
         data_size  = 2'($urandom_range(0, 3));
         data_addr  = $urandom;
         data_wdata = $urandom;
      end
   endtask

   task automatic issue(input bit wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd);
      data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
   endtask

   task automatic drain();
      bit acc;
      data_req = 0;
      for (int k = 0; k < 80 && busy; k++) begin
         slave_rand();
         tick(acc);
      end
      if (busy) chk("drain_timeout", 32'd1, 32'd0);
      slave_idle();
   endtask

   initial begin
      bit acc;
      int base;
      rst = 0; data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      rdata = 0; rlast = 1;
      slave_idle();
      model_reset();
      @(negedge clk);
      tick(acc);
      // reset state and constant attributes
      chk("rst_arvalid", {31'b0, arvalid}, 32'd0);
      chk("rst_awvalid", {31'b0, awvalid}, 32'd0);
      chk("rst_wvalid",  {31'b0, wvalid},  32'd0);
      chk("rst_araddr",  araddr, 32'd0);
      chk("const_ids", {20'b0, arid, awid, wid}, 32'h111);
      chk("const_len", {24'b0, arlen, awlen}, 32'h00);
      chk("const_burst", {28'b0, arburst, awburst}, 32'h5);
      chk("const_misc", {6'b0, arlock, awlock, arcache, awcache, arprot, awprot}, 32'd0);

      // word read, minimum latency, first cycle after reset release
      rst = 1;
      issue(0, 2'd2, 32'h0000_1004, 32'h0); arready = 1;
      #1 chk("rd_c0_addr_ok", {31'b0, data_addr_ok}, 32'd1);
      tick(acc);
      chk("rd_accept_first_cycle", {31'b0, acc}, 32'd1);
      data_req = 0;
      #1 chk("rd_c1_arvalid", {31'b0, arvalid}, 32'd1);
      chk("rd_c1_araddr", araddr, 32'h0000_1004);
      chk("rd_c1_arsize", {29'b0, arsize}, 32'd2);
      tick(acc);
      arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
      #1 chk("rd_c2_data_ok", {31'b0, data_data_ok}, 32'd1);
      chk("rd_c2_rdata", data_rdata, 32'hDEAD_BEEF);
      tick(acc);
      rvalid = 0;
      #1 chk("rd_c3_idle", {30'b0, data_addr_ok, data_data_ok}, 32'd2);
      tick(acc);

      // byte write to lane 3
      issue(1, 2'd0, 32'h0000_2003, 32'hAB00_0000);
      tick(acc);
      data_req = 0; awready = 1; wready = 1;
      #1 chk("bw_wstrb", {28'b0, wstrb}, 32'h8);
      chk("bw_awsize", {29'b0, awsize}, 32'd0);
      tick(acc);
      awready = 0; wready = 0; bvalid = 1;
      #1 chk("bw_data_ok", {31'b0, data_data_ok}, 32'd1);
      tick(acc);
      bvalid = 0;
      #1 chk("bw_single_pulse", {31'b0, data_data_ok}, 32'd0);
      tick(acc);

      // W handshake two cycles ahead of AW
      issue(1, 2'd2, 32'h0000_3000, 32'h1234_5678);
      tick(acc);
      data_req = 0; wready = 1;
      tick(acc);
      wready = 0;
      #1 chk("wfirst_wvalid_drop", {30'b0, wvalid, awvalid}, 32'd1);
      tick(acc);
      awready = 1;
      #1 chk("wfirst_no_resp_yet", {30'b0, awvalid, bready}, 32'd2);
      tick(acc);
      awready = 0; bvalid = 1;
      #1 chk("wfirst_resp", {30'b0, awvalid, bready}, 32'd1);
      tick(acc);
      bvalid = 0;

      // half write, both handshakes in the same cycle
      issue(1, 2'd1, 32'h0000_4002, 32'hBEEF_0000);
      tick(acc);
      data_req = 0; awready = 1; wready = 1;
      #1 chk("hw_wstrb", {28'b0, wstrb}, 32'hC);
      chk("hw_awsize", {29'b0, awsize}, 32'd1);
      tick(acc);
      awready = 0; wready = 0;
      #1 chk("hw_bready", {31'b0, bready}, 32'd1);
      tick(acc);
      bvalid = 1;
      tick(acc);
      bvalid = 0;

      // second request held high while the first read is outstanding
      base = accepts;
      issue(0, 2'd2, 32'h0000_5000, 32'h0);
      tick(acc);
      issue(0, 2'd0, 32'h0000_5009, 32'h0);
      for (int k = 0; k < 80 && data_req; k++) begin
         slave_rand();
         tick(acc);
         if (acc) data_req = 0;
      end
      drain();
      chk("held_req_accepts", accepts - base, 32'd2);

      // reset while waiting for read data
      issue(0, 2'd2, 32'h0000_6000, 32'h0);
      tick(acc);
      data_req = 0; arready = 1;
      tick(acc);
      arready = 0; rvalid = 1; rdata = 32'h1234_5678;
      rst = 0;
      model_reset();
      #1 chk("rst_mid_outputs", {29'b0, arvalid, rready, data_data_ok}, 32'd0);
      tick(acc);
      tick(acc);
      rst = 1;
      issue(0, 2'd2, 32'h0000_6004, 32'h0);
      tick(acc);
      chk("accept_after_rst", {31'b0, acc}, 32'd1);
      data_req = 0; rvalid = 0;
      drain();

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         up_rand();
         slave_rand();
         tick(acc);
         if (acc) data_req = 0;
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
